// File: rtl/picorv32_wb_arbiter.sv
// Round-robin arbiter sharing one Wishbone B3 classic master between two
// picorv32 native memory ports; single-beat cycles ended by ack, err or timeout.
module picorv32_wb_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_stb_o,
  output logic        wbm_cyc_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  output logic        grant,
  output logic        bus_err
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned CNT_W  = 8;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam bit               TO_EN    = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [SEL_W-1:0]  wstrb;
  } req_t;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  adr_q, adr_d;
  logic [DATA_W-1:0]  dat_q, dat_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               we_q, we_d;
  logic               cyc_q, cyc_d;
  logic               grant_q, grant_d;
  logic               m0_ready_q, m0_ready_d;
  logic               m1_ready_q, m1_ready_d;
  logic [DATA_W-1:0]  m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0]  m1_rdata_q, m1_rdata_d;
  logic               bus_err_q, bus_err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  req_t               m0_req, m1_req, win_req;
  logic               any_valid;
  logic               win_sel;
  logic               fault;

  // Winner selection: a lone requester wins; on a tie the non-last owner wins.
  always_comb begin
    m0_req    = '{addr: m0_addr, wdata: m0_wdata, wstrb: m0_wstrb};
    m1_req    = '{addr: m1_addr, wdata: m1_wdata, wstrb: m1_wstrb};
    any_valid = m0_valid | m1_valid;
    win_sel   = (m0_valid && m1_valid) ? ~grant_q : m1_valid;
    win_req   = win_sel ? m1_req : m0_req;
    fault     = wbm_err_i | (TO_EN && (cnt_q == TO_LIMIT));
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      adr_q      <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      cyc_q      <= 1'b0;
      grant_q    <= 1'b1;
      m0_ready_q <= 1'b0;
      m1_ready_q <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      bus_err_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      cyc_q      <= cyc_d;
      grant_q    <= grant_d;
      m0_ready_q <= m0_ready_d;
      m1_ready_q <= m1_ready_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
      bus_err_q  <= bus_err_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = any_valid ? S_BUS : S_IDLE;
      S_BUS:   state_d = (fault || wbm_ack_i) ? S_DONE : S_BUS;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic; ready and bus_err are single-cycle pulses by default.
  always_comb begin
    adr_d      = adr_q;
    dat_d      = dat_q;
    sel_d      = sel_q;
    we_d       = we_q;
    cyc_d      = cyc_q;
    grant_d    = grant_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    cnt_d      = cnt_q;
    m0_ready_d = 1'b0;
    m1_ready_d = 1'b0;
    bus_err_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        we_d  = 1'b0;
        cyc_d = 1'b0;
        if (any_valid) begin
          adr_d   = win_req.addr;
          dat_d   = win_req.wdata;
          sel_d   = win_req.wstrb;
          we_d    = |win_req.wstrb;
          cyc_d   = 1'b1;
          grant_d = win_sel;
          cnt_d   = '0;
        end
      end
      S_BUS: begin
        if (fault) begin
          // Error and timeout share one path and take priority over ack.
          cyc_d     = 1'b0;
          we_d      = 1'b0;
          bus_err_d = 1'b1;
          if (grant_q) begin
            m1_ready_d = 1'b1;
            m1_rdata_d = '0;
          end else begin
            m0_ready_d = 1'b1;
            m0_rdata_d = '0;
          end
        end else if (wbm_ack_i) begin
          cyc_d = 1'b0;
          we_d  = 1'b0;
          if (grant_q) begin
            m1_ready_d = 1'b1;
            m1_rdata_d = wbm_dat_i;
          end else begin
            m0_ready_d = 1'b1;
            m0_rdata_d = wbm_dat_i;
          end
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        cyc_d = 1'b0;
        we_d  = 1'b0;
      end
      default: begin
        adr_d      = '0;
        dat_d      = '0;
        sel_d      = '0;
        we_d       = 1'b0;
        cyc_d      = 1'b0;
        grant_d    = 1'b1;
        m0_rdata_d = '0;
        m1_rdata_d = '0;
        cnt_d      = '0;
      end
    endcase
  end

  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign wbm_sel_o = sel_q;
  assign wbm_we_o  = we_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign grant     = grant_q;
  assign m0_ready  = m0_ready_q;
  assign m1_ready  = m1_ready_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_picorv32_wb_arbiter.sv
// Directed bench for picorv32_wb_arbiter: transaction table plus corner sequences.
module tb_picorv32_wb_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic        wbm_we_o, wbm_stb_o, wbm_cyc_o, wbm_ack_i, wbm_err_i;
  logic [3:0]  wbm_sel_o;
  logic        grant, bus_err;

  logic        z_m0_valid, z_m1_valid;
  logic [31:0] z_m0_addr, z_m1_addr, z_m0_wdata, z_m1_wdata;
  logic [3:0]  z_m0_wstrb, z_m1_wstrb;
  logic        z_m0_ready, z_m1_ready;
  logic [31:0] z_m0_rdata, z_m1_rdata;
  logic [31:0] z_adr_o, z_dat_o, z_dat_i;
  logic        z_we_o, z_stb_o, z_cyc_o, z_ack_i, z_err_i;
  logic [3:0]  z_sel_o;
  logic        z_grant, z_bus_err;

  picorv32_wb_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
    .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o), .wbm_stb_o(wbm_stb_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
    .grant(grant), .bus_err(bus_err)
  );

  picorv32_wb_arbiter #(.TIMEOUT_CYCLES(0)) dut_noto (
    .clk(clk), .resetn(resetn),
    .m0_valid(z_m0_valid), .m0_addr(z_m0_addr), .m0_wdata(z_m0_wdata), .m0_wstrb(z_m0_wstrb),
    .m0_ready(z_m0_ready), .m0_rdata(z_m0_rdata),
    .m1_valid(z_m1_valid), .m1_addr(z_m1_addr), .m1_wdata(z_m1_wdata), .m1_wstrb(z_m1_wstrb),
    .m1_ready(z_m1_ready), .m1_rdata(z_m1_rdata),
    .wbm_adr_o(z_adr_o), .wbm_dat_o(z_dat_o), .wbm_dat_i(z_dat_i),
    .wbm_we_o(z_we_o), .wbm_sel_o(z_sel_o), .wbm_stb_o(z_stb_o),
    .wbm_cyc_o(z_cyc_o), .wbm_ack_i(z_ack_i), .wbm_err_i(z_err_i),
    .grant(z_grant), .bus_err(z_bus_err)
  );

  typedef struct {
    logic        v0, v1;
    logic [31:0] a0, d0, a1, d1;
    logic [3:0]  s0, s1;
    int          dly;
    logic        ack, err;
    logic [31:0] sdat;
    logic        exp_gnt;
    logic [31:0] exp_rd;
    logic        exp_berr;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_rd0, exp_rd1;

  function automatic vec_t mk(input logic v0, input logic [31:0] a0, input logic [31:0] d0,
                              input logic [3:0] s0, input logic v1, input logic [31:0] a1,
                              input logic [31:0] d1, input logic [3:0] s1, input int dly,
                              input logic ack, input logic err, input logic [31:0] sdat,
                              input logic gnt, input logic [31:0] rd, input logic berr);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.d0 = d0; v.s0 = s0;
    v.v1 = v1; v.a1 = a1; v.d1 = d1; v.s1 = s1;
    v.dly = dly; v.ack = ack; v.err = err; v.sdat = sdat;
    v.exp_gnt = gnt; v.exp_rd = rd; v.exp_berr = berr;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_cyc();
    int n;
    n = 0;
    while (!wbm_cyc_o && n < 20) begin
      step();
      n++;
    end
    chk("cyc_rise", 32'(wbm_cyc_o), 32'd1);
  endtask

  vec_t vecs[7];

  initial begin : wdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int gap, n, bad;
    vec_t v;
    logic [31:0] w_adr, w_dat;
    logic [3:0]  w_sel;

    vecs[0] = mk(1, 32'h100, 32'h0, 4'h0, 0, 32'h0, 32'h0, 4'h0, 2, 1, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0);
    vecs[1] = mk(0, 32'h0, 32'h0, 4'h0, 1, 32'h2004, 32'h12345678, 4'b0110, 1, 1, 0, 32'hAAAA5555, 1, 32'hAAAA5555, 0);
    vecs[2] = mk(1, 32'h300, 32'h0, 4'h0, 1, 32'h400, 32'h0, 4'h0, 0, 1, 0, 32'h11112222, 0, 32'h11112222, 0);
    vecs[3] = mk(1, 32'h300, 32'h0, 4'h0, 1, 32'h400, 32'h0, 4'h0, 0, 1, 0, 32'h33334444, 1, 32'h33334444, 0);
    vecs[4] = mk(1, 32'h310, 32'h0, 4'h0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 1, 32'hFFFF0000, 0, 32'h0, 1);
    vecs[5] = mk(0, 32'h0, 32'h0, 4'h0, 1, 32'h410, 32'h0, 4'h0, 1, 0, 1, 32'h55550000, 1, 32'h0, 1);
    vecs[6] = mk(1, 32'h8, 32'hCAFEF00D, 4'hF, 0, 32'h0, 32'h0, 4'h0, 3, 1, 0, 32'h0BADF00D, 0, 32'h0BADF00D, 0);

    resetn = 1'b0;
    m0_valid = 0; m1_valid = 0; m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
    m0_wstrb = 0; m1_wstrb = 0; wbm_dat_i = 0; wbm_ack_i = 0; wbm_err_i = 0;
    z_m0_valid = 0; z_m1_valid = 0; z_m0_addr = 0; z_m1_addr = 0; z_m0_wdata = 0; z_m1_wdata = 0;
    z_m0_wstrb = 0; z_m1_wstrb = 0; z_dat_i = 0; z_ack_i = 0; z_err_i = 0;
    exp_rd0 = 0; exp_rd1 = 0;
    repeat (3) step();

    chk("rst_cyc", 32'(wbm_cyc_o), 32'd0);
    chk("rst_stb", 32'(wbm_stb_o), 32'd0);
    chk("rst_we", 32'(wbm_we_o), 32'd0);
    chk("rst_adr", wbm_adr_o, 32'd0);
    chk("rst_dat", wbm_dat_o, 32'd0);
    chk("rst_sel", 32'(wbm_sel_o), 32'd0);
    chk("rst_m0_ready", 32'(m0_ready), 32'd0);
    chk("rst_m1_ready", 32'(m1_ready), 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'd0);
    chk("rst_m1_rdata", m1_rdata, 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_grant", 32'(grant), 32'd1);
    resetn = 1'b1;
    step();

    // Both requesters held valid with a zero-wait slave: strict alternation.
    m0_valid = 1; m0_addr = 32'h1000; m1_valid = 1; m1_addr = 32'h2000;
    for (int i = 0; i < 4; i++) begin
      wait_cyc();
      chk("alt_grant", 32'(grant), 32'(i % 2));
      chk("alt_adr", wbm_adr_o, (i % 2 == 1) ? 32'h2000 : 32'h1000);
      wbm_ack_i = 1; wbm_dat_i = 32'hA0 + 32'(i);
      step();
      wbm_ack_i = 0;
      chk("alt_cyc_len", 32'(wbm_cyc_o), 32'd0);
      chk("alt_ready", (i % 2 == 1) ? 32'(m1_ready) : 32'(m0_ready), 32'd1);
      chk("alt_other_ready", (i % 2 == 1) ? 32'(m0_ready) : 32'(m1_ready), 32'd0);
      chk("alt_rdata", (i % 2 == 1) ? m1_rdata : m0_rdata, 32'hA0 + 32'(i));
      if (i % 2 == 1) exp_rd1 = 32'hA0 + 32'(i); else exp_rd0 = 32'hA0 + 32'(i);
      if (i == 3) begin
        m0_valid = 0; m1_valid = 0;
      end else begin
        gap = 0;
        while (!wbm_cyc_o && gap < 20) begin
          gap++;
          step();
        end
        chk("alt_gap", 32'(gap), 32'd2);
      end
    end
    step(); step();

    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      m0_valid = v.v0; m0_addr = v.a0; m0_wdata = v.d0; m0_wstrb = v.s0;
      m1_valid = v.v1; m1_addr = v.a1; m1_wdata = v.d1; m1_wstrb = v.s1;
      w_adr = v.exp_gnt ? v.a1 : v.a0;
      w_dat = v.exp_gnt ? v.d1 : v.d0;
      w_sel = v.exp_gnt ? v.s1 : v.s0;
      wait_cyc();
      chk("vec_grant", 32'(grant), 32'(v.exp_gnt));
      chk("vec_stb", 32'(wbm_stb_o), 32'd1);
      chk("vec_adr", wbm_adr_o, w_adr);
      chk("vec_sel", 32'(wbm_sel_o), 32'(w_sel));
      chk("vec_we", 32'(wbm_we_o), 32'(|w_sel));
      if (|w_sel) chk("vec_dat", wbm_dat_o, w_dat);
      for (int k = 0; k < v.dly; k++) begin
        step();
        chk("vec_hold_cyc", 32'(wbm_cyc_o), 32'd1);
        chk("vec_hold_sel", 32'(wbm_sel_o), 32'(w_sel));
        chk("vec_hold_we", 32'(wbm_we_o), 32'(|w_sel));
        chk("vec_m0_ready_idle", 32'(m0_ready), 32'd0);
      end
      wbm_ack_i = v.ack; wbm_err_i = v.err; wbm_dat_i = v.sdat;
      step();
      wbm_ack_i = 0; wbm_err_i = 0;
      m0_valid = 0; m1_valid = 0;
      chk("vec_cyc_drop", 32'(wbm_cyc_o), 32'd0);
      chk("vec_we_drop", 32'(wbm_we_o), 32'd0);
      chk("vec_ready", v.exp_gnt ? 32'(m1_ready) : 32'(m0_ready), 32'd1);
      chk("vec_other_ready", v.exp_gnt ? 32'(m0_ready) : 32'(m1_ready), 32'd0);
      chk("vec_rdata", v.exp_gnt ? m1_rdata : m0_rdata, v.exp_rd);
      chk("vec_other_rdata", v.exp_gnt ? m0_rdata : m1_rdata, v.exp_gnt ? exp_rd0 : exp_rd1);
      chk("vec_bus_err", 32'(bus_err), 32'(v.exp_berr));
      if (v.exp_gnt) exp_rd1 = v.exp_rd; else exp_rd0 = v.exp_rd;
      step();
      chk("vec_ready_clr", 32'(m0_ready | m1_ready), 32'd0);
      chk("vec_bus_err_clr", 32'(bus_err), 32'd0);
      step();
    end

    // Timeout of 4: cyc high for 5 cycles then error completion.
    m0_valid = 1; m0_addr = 32'h600; m0_wstrb = 0;
    wait_cyc();
    n = 0;
    while (wbm_cyc_o && n < 50) begin
      n++;
      step();
    end
    m0_valid = 0;
    chk("to_cyc_len", 32'(n), 32'd5);
    chk("to_m0_ready", 32'(m0_ready), 32'd1);
    chk("to_m0_rdata", m0_rdata, 32'd0);
    chk("to_bus_err", 32'(bus_err), 32'd1);
    chk("to_m1_ready", 32'(m1_ready), 32'd0);
    exp_rd0 = 0;
    step();
    chk("to_bus_err_clr", 32'(bus_err), 32'd0);
    chk("to_ready_clr", 32'(m0_ready), 32'd0);
    step();

    // Timeout disabled: cyc held well past the 8-bit counter range.
    z_m0_valid = 1; z_m0_addr = 32'h700;
    n = 0;
    while (!z_cyc_o && n < 20) begin
      step();
      n++;
    end
    chk("z_cyc_rise", 32'(z_cyc_o), 32'd1);
    chk("z_adr", z_adr_o, 32'h700);
    bad = 0;
    for (int k = 0; k < 300; k++) begin
      step();
      if (!z_cyc_o || z_bus_err || z_m0_ready) bad++;
    end
    chk("z_no_timeout", 32'(bad), 32'd0);
    z_ack_i = 1; z_dat_i = 32'h77;
    step();
    z_ack_i = 0; z_m0_valid = 0;
    chk("z_ready", 32'(z_m0_ready), 32'd1);
    chk("z_rdata", z_m0_rdata, 32'h77);
    chk("z_bus_err", 32'(z_bus_err), 32'd0);
    step();

    // Owner drops valid and changes address mid-cycle; request still completes.
    m0_valid = 1; m0_addr = 32'h500; m0_wstrb = 0;
    wait_cyc();
    m0_valid = 0; m0_addr = 32'hFFFF_FFF0;
    step();
    chk("drop_cyc", 32'(wbm_cyc_o), 32'd1);
    chk("drop_adr", wbm_adr_o, 32'h500);
    step();
    chk("drop_cyc2", 32'(wbm_cyc_o), 32'd1);
    wbm_ack_i = 1; wbm_dat_i = 32'h5A5A5A5A;
    step();
    wbm_ack_i = 0;
    chk("drop_ready", 32'(m0_ready), 32'd1);
    chk("drop_rdata", m0_rdata, 32'h5A5A5A5A);
    exp_rd0 = 32'h5A5A5A5A;
    step(); step();

    // Reset asserted while the slave is stalling a write.
    m0_valid = 1; m0_addr = 32'h900; m0_wdata = 32'h99; m0_wstrb = 4'hF;
    wait_cyc();
    chk("rstmid_grant_pre", 32'(grant), 32'd0);
    step();
    #2;
    resetn = 1'b0;
    m0_valid = 0;
    #1;
    chk("rstmid_cyc", 32'(wbm_cyc_o), 32'd0);
    chk("rstmid_stb", 32'(wbm_stb_o), 32'd0);
    chk("rstmid_we", 32'(wbm_we_o), 32'd0);
    chk("rstmid_adr", wbm_adr_o, 32'd0);
    chk("rstmid_dat", wbm_dat_o, 32'd0);
    chk("rstmid_sel", 32'(wbm_sel_o), 32'd0);
    chk("rstmid_m0_rdata", m0_rdata, 32'd0);
    chk("rstmid_grant", 32'(grant), 32'd1);
    step();
    resetn = 1'b1;
    m0_valid = 1; m0_addr = 32'hA00; m0_wstrb = 0;
    m1_valid = 1; m1_addr = 32'hB00; m1_wstrb = 0;
    wait_cyc();
    chk("rstmid_tie_grant", 32'(grant), 32'd0);
    chk("rstmid_tie_adr", wbm_adr_o, 32'hA00);
    wbm_ack_i = 1; wbm_dat_i = 32'h0C0C0C0C;
    step();
    wbm_ack_i = 0; m0_valid = 0; m1_valid = 0;
    chk("rstmid_ready", 32'(m0_ready), 32'd1);
    chk("rstmid_rdata", m0_rdata, 32'h0C0C0C0C);
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
